sensor_emu_fifo_player: RTL
===========================

Name: sensor_emu_fifo_player

Overview:
Playback core of the sensor emulator, directly downstream of the emulator AXI control-register block. Consumes its FIFO-control, load, start and hard-stop strobes. Stores 64-bit cell patterns in two internal pattern FIFOs and replays the selected FIFO cyclically onto an AXI-Stream master. Returns status words to the register block: reset status, per-FIFO counts, active FIFO and pattern width.

Parameters:
DEPTH, 1024, entries per pattern FIFO; power of 2, minimum 4
RESET_CYCLES, 16, cycles a FIFO reset status stays asserted; minimum 1

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
i_fifo_ctl_f0_reset  in  1  request FIFO0 reset; qualified by i_fifo_ctl_wstrobe
i_fifo_ctl_f1_reset  in  1  request FIFO1 reset; qualified by i_fifo_ctl_wstrobe
i_fifo_ctl_wstrobe  in  1  FIFO-control write strobe
i_upper32  in  32  upper half of the word to be loaded
i_load_f0  in  32  lower half of the FIFO0 load word
i_load_f0_wstrobe  in  1  load into FIFO0
i_load_f1  in  32  lower half of the FIFO1 load word
i_load_f1_wstrobe  in  1  load into FIFO1
i_start  in  2  1 = play FIFO0, 2 = play FIFO1, 0 = stop at end of pass, 3 = no-op
i_start_wstrobe  in  1  start-command strobe
i_hard_stop_wstrobe  in  1  immediate stop
o_pattern_width  out  4  constant 8 (bytes per pattern)
o_fifo_stat_f0_reset  out  1  FIFO0 reset in progress
o_fifo_stat_f1_reset  out  1  FIFO1 reset in progress
o_f0_count  out  32  entries in FIFO0
o_f1_count  out  32  entries in FIFO1
o_active_fifo  out  2  0 = idle, 1 = FIFO0, 2 = FIFO1
m_axis_tdata  out  64  pattern word
m_axis_tvalid  out  1  beat valid
m_axis_tlast  out  1  last entry of the current pass
m_axis_tready  in  1  downstream ready

Behaviour:
- Reset state: counts 0; all status outputs 0; tvalid, tlast and tdata 0; o_active_fifo 0; o_pattern_width 8. Reset mid-playback aborts the stream with no completing beat.
- Load into FIFO N:
  - Write {i_upper32, i_load_fN} at index countN, then countN+1.
  - The load is silently ignored if countN == DEPTH, FIFO N is active, or FIFO N is resetting.
- FIFO reset:
  - i_fifo_ctl_wstrobe with bit N set clears countN on the next edge.
  - o_fifo_stat_fN_reset is high for exactly RESET_CYCLES cycles. A re-trigger restarts the timer.
  - If FIFO N is active, playback is hard-stopped.
  - A reset strobe beats a same-cycle load to the same FIFO; the load is dropped.
- State machine IDLE / PLAY / DRAIN:
  - IDLE + start 1 or 2, with the target count > 0 and the target not resetting → PLAY. Otherwise the command is ignored.
  - On entry to PLAY: o_active_fifo updates at T+1 (T = strobe cycle); first tvalid at T+2 (1-cycle registered memory read).
  - PLAY: index runs 0..count-1, then wraps to 0. tlast is set on index count-1.
  - Throughput is one beat per cycle while tready = 1. Under tvalid && !tready, tdata and tlast are held stable.
  - PLAY + start 1 or 2 (valid target): the command is latched as pending. The switch happens right after the tlast beat handshakes, and the first beat of the new FIFO follows with no gap. A later command overwrites the pending one.
  - PLAY + start 0 → DRAIN: finish the current pass; after the tlast handshake go to IDLE with active = 0.
  - Hard stop, from any state: next cycle tvalid = 0, active = 0, pending command cleared, state IDLE. This beat abort is a documented AXIS exception.
  - Hard stop and start in the same cycle: hard stop wins.
- Counts are zero-extended to 32 bits.

Optional Feature:
SENSOR_EMU_ONESHOT_EN
- Defined: PLAY automatically behaves as DRAIN. Exactly one pass is sent, then IDLE after the tlast handshake. A pending switch still applies at the pass boundary and also plays once.
- Undefined: continuous looping as described in Behaviour.

Test Plan:
- Load F0 with i_upper32 = 0x0000000A and loads 1, 2, 3; start = 1; tready = 1 → beats 0x0000000A_00000001, _00000002, _00000003 (tlast), then _00000001 repeats; f0_count = 3; active = 1.
- Load DEPTH + 1 words into F1 → f1_count = DEPTH; the extra word is absent from playback.
- tready low for 5 cycles mid-pass → tdata and tlast stable throughout; beat sequence has no loss or duplication.
- F0 (3 entries) active; issue start = 2 mid-pass → F0 completes through its tlast, next beat is F1[0], active = 2.
- Hard stop mid-pass → tvalid = 0 and active = 0 next cycle. FIFO reset of the active FIFO → stat high for 16 cycles, count 0, playback stopped.
- start = 1 with f0_count = 0 → ignored; active stays 0 and no tvalid.

Source files
------------

// File: rtl/sensor_emu_fifo_player.sv
// Playback core: two 64-bit pattern FIFOs replayed onto an AXI-Stream master, with per-FIFO reset timers.
// Optional SENSOR_EMU_ONESHOT_EN: every started or switched-to FIFO is played for exactly one pass.
module sensor_emu_fifo_player #(
  parameter int DEPTH        = 1024,
  parameter int RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_fifo_ctl_f0_reset,
  input  logic        i_fifo_ctl_f1_reset,
  input  logic        i_fifo_ctl_wstrobe,
  input  logic [31:0] i_upper32,
  input  logic [31:0] i_load_f0,
  input  logic        i_load_f0_wstrobe,
  input  logic [31:0] i_load_f1,
  input  logic        i_load_f1_wstrobe,
  input  logic [1:0]  i_start,
  input  logic        i_start_wstrobe,
  input  logic        i_hard_stop_wstrobe,
  output logic [3:0]  o_pattern_width,
  output logic        o_fifo_stat_f0_reset,
  output logic        o_fifo_stat_f1_reset,
  output logic [31:0] o_f0_count,
  output logic [31:0] o_f1_count,
  output logic [1:0]  o_active_fifo,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
`ifdef SENSOR_EMU_ONESHOT_EN
  localparam logic [1:0] ST_RUN = ST_DRAIN;
`else
  localparam logic [1:0] ST_RUN = ST_PLAY;
`endif

  logic [1:0]          state_q, state_d;
  logic [1:0]          active_q, active_d;
  logic [1:0]          pending_q, pending_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                beat_sel_q, beat_sel_d;
  logic [1:0][AW:0]    count_q, count_d;
  logic [1:0][TW-1:0]  rtimer_q, rtimer_d;

  logic [1:0]          rst_req, load_stb, wr_en, rd_en, tgt_ok, resetting;
  logic [1:0][31:0]    load_lo;
  logic [1:0][63:0]    rd_data;
  logic                start_ok, hard_stop, sel, go_idle;

  assign rst_req  = {2{i_fifo_ctl_wstrobe}} & {i_fifo_ctl_f1_reset, i_fifo_ctl_f0_reset};
  assign load_stb = {i_load_f1_wstrobe, i_load_f0_wstrobe};
  assign load_lo  = {i_load_f1, i_load_f0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [63:0] mem [DEPTH];
      logic [63:0] rd_q;

      assign resetting[gi] = (rtimer_q[gi] != '0);
      assign tgt_ok[gi]    = (count_q[gi] != '0) && !resetting[gi] && !rst_req[gi];
      // A reset strobe wins over a same-cycle load; loads into the playing FIFO are dropped.
      assign wr_en[gi]     = load_stb[gi] && !rst_req[gi] && !resetting[gi]
                             && (count_q[gi] != (AW + 1)'(DEPTH)) && (active_q != 2'(gi + 1));
      assign count_d[gi]   = rst_req[gi] ? '0 : (wr_en[gi] ? count_q[gi] + 1'b1 : count_q[gi]);
      assign rtimer_d[gi]  = rst_req[gi] ? TW'(RESET_CYCLES)
                             : (resetting[gi] ? rtimer_q[gi] - 1'b1 : rtimer_q[gi]);

      always_ff @(posedge clk) begin
        if (wr_en[gi]) mem[count_q[gi][AW-1:0]] <= {i_upper32, load_lo[gi]};
        if (rd_en[gi]) rd_q <= mem[idx_q];
      end
      assign rd_data[gi] = rd_q;
    end
  endgenerate

  assign start_ok  = i_start_wstrobe && (i_start == 2'd1 || i_start == 2'd2) && tgt_ok[i_start[1]];
  assign hard_stop = i_hard_stop_wstrobe || (active_q != 2'd0 && rst_req[active_q[1]]);

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pending_d  = pending_q;
    idx_d      = idx_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    beat_sel_d = beat_sel_q;
    rd_en      = '0;
    sel        = active_q[1];
    go_idle    = 1'b0;
    if (hard_stop) begin
      go_idle = 1'b1;
    end else if (state_q == ST_IDLE) begin
      if (start_ok) begin
        state_d  = ST_RUN;
        active_d = i_start;
        idx_d    = '0;
      end
    end else begin
      // Pass boundary: the tlast beat is handshaking now, so the next read picks the next source.
      if (tvalid_q && tlast_q && m_axis_tready) begin
        pending_d = '0;
        if (pending_q != 2'd0 && tgt_ok[pending_q[1]]) begin
          sel      = pending_q[1];
          active_d = pending_q;
          state_d  = ST_RUN;
        end else if (state_q == ST_DRAIN) begin
          go_idle = 1'b1;
        end
      end
      if (!go_idle) begin
        if (i_start_wstrobe && i_start == 2'd0) begin
          state_d   = ST_DRAIN;
          pending_d = '0;
        end else if (start_ok) begin
          pending_d = i_start;
        end
        if (!tvalid_q || m_axis_tready) begin
          rd_en[sel] = 1'b1;
          tvalid_d   = 1'b1;
          beat_sel_d = sel;
          tlast_d    = ({1'b0, idx_q} == count_q[sel] - 1'b1);
          idx_d      = tlast_d ? '0 : idx_q + 1'b1;
        end
      end
    end
    if (go_idle) begin
      state_d   = ST_IDLE;
      active_d  = 2'd0;
      pending_d = 2'd0;
      idx_d     = '0;
      tvalid_d  = 1'b0;
      tlast_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      active_q   <= 2'd0;
      pending_q  <= 2'd0;
      idx_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      beat_sel_q <= 1'b0;
      count_q    <= '0;
      rtimer_q   <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      beat_sel_q <= beat_sel_d;
      count_q    <= count_d;
      rtimer_q   <= rtimer_d;
    end
  end

  assign o_pattern_width      = 4'd8;
  assign o_fifo_stat_f0_reset = resetting[0];
  assign o_fifo_stat_f1_reset = resetting[1];
  assign o_f0_count           = 32'(count_q[0]);
  assign o_f1_count           = 32'(count_q[1]);
  assign o_active_fifo        = active_q;
  assign m_axis_tvalid        = tvalid_q;
  assign m_axis_tlast         = tlast_q;
  assign m_axis_tdata         = tvalid_q ? rd_data[beat_sel_q] : 64'd0;

endmodule
